// File: rtl/des_key_schedule.sv
// DES key-schedule generator: PC-1 on key acceptance, per-beat C/D rotation,
// and a valid/ready stream of the 16 PC-2 round keys in encrypt or decrypt order.
module des_key_schedule #(
   parameter bit CHECK_PARITY = 1'b0,
   parameter bit PC1_REG      = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_valid,
   output logic        key_ready,
   input  logic [63:0] key_in,
   input  logic        decrypt,
   output logic        subkey_valid,
   input  logic        subkey_ready,
   output logic [47:0] subkey,
   output logic [3:0]  subkey_idx,
   output logic        subkey_last,
   output logic        key_err,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      GEN  = 2'd2
   } state_t;

   // Table entries are DES bit numbers (1-based, bit 1 = MSB).
   localparam logic [6:0] PC1_TBL [56] = '{
      7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
      7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
      7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
      7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
      7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
      7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
      7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
      7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
   };

   localparam logic [5:0] PC2_TBL [48] = '{
      6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
      6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
      6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
      6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
      6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
      6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
      6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
      6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
   };

   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      r = 56'd0;
      for (int i = 0; i < 56; i++) begin
         r[55-i] = k[6'(7'd64 - PC1_TBL[i])];
      end
      return r;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] r;
      r = 48'd0;
      for (int i = 0; i < 48; i++) begin
         r[47-i] = cd[6'(6'd56 - PC2_TBL[i])];
      end
      return r;
   endfunction

   function automatic logic odd_parity_ok(input logic [63:0] k);
      logic ok;
      ok = 1'b1;
      for (int b = 0; b < 8; b++) begin
         ok = ok & (^k[8*b +: 8]);
      end
      return ok;
   endfunction

   // Rotation amount for DES round 1..16.
   function automatic logic [1:0] shift_amt(input logic [4:0] round);
      case (round)
         5'd1, 5'd2, 5'd9, 5'd16: shift_amt = 2'd1;
         default:                 shift_amt = 2'd2;
      endcase
   endfunction

   function automatic logic [27:0] rot28(input logic [27:0] x, input logic right, input logic [1:0] amt);
      case ({right, amt})
         3'b001:  rot28 = {x[26:0], x[27]};
         3'b010:  rot28 = {x[25:0], x[27:26]};
         3'b101:  rot28 = {x[0], x[27:1]};
         3'b110:  rot28 = {x[1:0], x[27:2]};
         default: rot28 = x;
      endcase
   endfunction

   state_t      state_r;
   logic [27:0] c_r;
   logic [27:0] d_r;
   logic        dec_r;

   logic [55:0] pc1_s;
   logic [55:0] base_cd_s;
   logic        rot_dir_s;
   logic [1:0]  rot_amt_s;
   logic [27:0] next_c_s;
   logic [27:0] next_d_s;
   logic [47:0] next_key_s;
   logic        parity_ok_s;

   // Next C/D halves and the round key they produce for the upcoming beat.
   always_comb begin
      pc1_s       = pc1(key_in);
      parity_ok_s = odd_parity_ok(key_in);
      base_cd_s   = {c_r, d_r};
      rot_dir_s   = dec_r;
      rot_amt_s   = 2'd0;
      case (state_r)
         IDLE: begin
            base_cd_s = pc1_s;
            rot_dir_s = decrypt;
            rot_amt_s = decrypt ? 2'd0 : 2'd1;
         end
         LOAD: begin
            rot_amt_s = dec_r ? 2'd0 : 2'd1;
         end
         GEN: begin
            // Decrypt walks the schedule backwards, undoing round (16 - idx).
            if (dec_r) begin
               rot_amt_s = shift_amt(5'd16 - {1'b0, subkey_idx});
            end else begin
               rot_amt_s = shift_amt({1'b0, subkey_idx} + 5'd2);
            end
         end
         default: begin
            rot_amt_s = 2'd0;
         end
      endcase
      next_c_s   = rot28(base_cd_s[55:28], rot_dir_s, rot_amt_s);
      next_d_s   = rot28(base_cd_s[27:0], rot_dir_s, rot_amt_s);
      next_key_s = pc2({next_c_s, next_d_s});
   end

   // Control FSM with registered handshake and subkey outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         c_r          <= 28'd0;
         d_r          <= 28'd0;
         dec_r        <= 1'b0;
         key_ready    <= 1'b1;
         busy         <= 1'b0;
         subkey_valid <= 1'b0;
         subkey       <= 48'd0;
         subkey_idx   <= 4'd0;
         subkey_last  <= 1'b0;
         key_err      <= 1'b0;
      end else begin
         key_err <= 1'b0;
         case (state_r)
            IDLE: begin
               if (key_valid) begin
                  if (CHECK_PARITY && !parity_ok_s) begin
                     key_err <= 1'b1;
                  end else begin
                     dec_r       <= decrypt;
                     subkey_idx  <= 4'd0;
                     subkey_last <= 1'b0;
                     key_ready   <= 1'b0;
                     busy        <= 1'b1;
                     if (PC1_REG) begin
                        c_r     <= pc1_s[55:28];
                        d_r     <= pc1_s[27:0];
                        state_r <= LOAD;
                     end else begin
                        c_r          <= next_c_s;
                        d_r          <= next_d_s;
                        subkey       <= next_key_s;
                        subkey_valid <= 1'b1;
                        state_r      <= GEN;
                     end
                  end
               end
            end
            LOAD: begin
               c_r          <= next_c_s;
               d_r          <= next_d_s;
               subkey       <= next_key_s;
               subkey_valid <= 1'b1;
               state_r      <= GEN;
            end
            GEN: begin
               if (subkey_ready) begin
                  if (subkey_idx == 4'd15) begin
                     subkey_valid <= 1'b0;
                     subkey_last  <= 1'b0;
                     subkey_idx   <= 4'd0;
                     key_ready    <= 1'b1;
                     busy         <= 1'b0;
                     state_r      <= IDLE;
                  end else begin
                     c_r         <= next_c_s;
                     d_r         <= next_d_s;
                     subkey      <= next_key_s;
                     subkey_idx  <= subkey_idx + 4'd1;
                     subkey_last <= (subkey_idx == 4'd14);
                  end
               end
            end
            default: begin
               state_r      <= IDLE;
               key_ready    <= 1'b1;
               busy         <= 1'b0;
               subkey_valid <= 1'b0;
               subkey_last  <= 1'b0;
               subkey_idx   <= 4'd0;
            end
         endcase
      end
   end

endmodule
